// File: rtl/wb_pkg.sv
// Shared types and defaults for the writeback controller.
//   WB_AW / WB_DEPTH : default register-address width and load-queue depth
//   reg_addr_t       : register address at the default width
//   wb_src_e         : writeback mux select encoding (drives memtoreg)
package wb_pkg;

    localparam int unsigned WB_AW    = 5;
    localparam int unsigned WB_DEPTH = 4;

    typedef logic [WB_AW-1:0] reg_addr_t;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_MEM = 1'b1
    } wb_src_e;

endpackage

// File: rtl/ld_tag_fifo.sv
// In-order queue of outstanding load destination registers.
//   clk, rst      : clock, async active-high reset
//   push, din     : enqueue din (ignored when full)
//   pop           : dequeue oldest entry (ignored when empty)
//   head_data     : oldest entry
//   full, empty   : occupancy flags
//   count         : number of valid entries
//   entries       : all storage slots, slot i at [i*AW +: AW]
//   entry_valid   : per-slot valid bits for the parallel hazard compare
module ld_tag_fifo
    import wb_pkg::*;
#(
    parameter int unsigned AW    = WB_AW,
    parameter int unsigned DEPTH = WB_DEPTH,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [AW-1:0]         din,
    input  logic                  pop,
    output logic [AW-1:0]         head_data,
    output logic                  full,
    output logic                  empty,
    output logic [CW-1:0]         count,
    output logic [DEPTH*AW-1:0]   entries,
    output logic [DEPTH-1:0]      entry_valid
);

    logic [AW-1:0] mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          push_ok;
    logic          pop_ok;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign push_ok   = push && !full;
    assign pop_ok    = pop && !empty;
    assign head_data = mem[head];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[tail] <= din;
                tail      <= tail + PW'(1);
            end
            if (pop_ok) begin
                head <= head + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // A slot is live when its distance from head is below count.
    always_comb begin
        entries     = '0;
        entry_valid = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            entries[i*AW +: AW] = mem[i];
            entry_valid[i]      = (CW'(PW'(PW'(i) - head)) < count);
        end
    end

endmodule

// File: rtl/wb_ctrl.sv
// Writeback controller: arbitrates the register-file write port between
// in-order load returns and single-cycle ALU results, stalling ALU writes
// that would overtake a pending load to the same register.
//   clk, rst            : clock, async active-high reset
//   alu_valid, alu_rd   : ALU result request and destination
//   alu_stall           : ALU request not accepted this cycle
//   ld_req, ld_rd       : load issue, destination pushed into tag queue
//   ld_ready            : tag queue has room
//   mem_valid           : data for oldest outstanding load is returning
//   memtoreg            : writeback mux select (1 = memory, 0 = ALU)
//   rf_we, rf_waddr     : register-file write port control
//   pending             : outstanding load count
//   wb_err              : sticky, a load return arrived with nothing pending
module wb_ctrl
    import wb_pkg::*;
#(
    parameter int unsigned W     = 32,
    parameter int unsigned AW    = WB_AW,
    parameter int unsigned DEPTH = WB_DEPTH,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_rd,
    output logic          alu_stall,
    input  logic          ld_req,
    input  logic [AW-1:0] ld_rd,
    output logic          ld_ready,
    input  logic          mem_valid,
    output logic          memtoreg,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [CW-1:0] pending,
    output logic          wb_err
);

    // Elaboration-time parameter sanity.
    if (W == 0) begin : g_bad_width
        $error("wb_ctrl: W must be non-zero");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("wb_ctrl: DEPTH must be a power of two and at least 2");
    end

    logic [AW-1:0]       head_rd;
    logic                q_full;
    logic                q_empty;
    logic [CW-1:0]       q_count;
    logic [DEPTH*AW-1:0] q_entries;
    logic [DEPTH-1:0]    q_valid;
    logic                mem_wb;
    logic                tag_hit;
    logic                hazard;
    wb_src_e             wb_src;

    ld_tag_fifo #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_tags (
        .clk         (clk),
        .rst         (rst),
        .push        (ld_req),
        .din         (ld_rd),
        .pop         (mem_valid),
        .head_data   (head_rd),
        .full        (q_full),
        .empty       (q_empty),
        .count       (q_count),
        .entries     (q_entries),
        .entry_valid (q_valid)
    );

    assign ld_ready = !q_full;
    assign pending  = q_count;
    assign mem_wb   = mem_valid && !q_empty;

    // WAW check against registered queue contents only; same-cycle pushes
    // become visible next cycle.
    always_comb begin
        tag_hit = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (q_valid[i] && (q_entries[i*AW +: AW] == alu_rd)) begin
                tag_hit = 1'b1;
            end
        end
    end

    assign hazard = alu_valid && (alu_rd != '0) && tag_hit;

    // Write-port priority: load return, then hazard stall, then ALU.
    always_comb begin
        wb_src    = WB_ALU;
        rf_we     = 1'b0;
        rf_waddr  = '0;
        alu_stall = 1'b0;
        if (mem_wb) begin
            wb_src    = WB_MEM;
            rf_waddr  = head_rd;
            rf_we     = (head_rd != '0);
            alu_stall = alu_valid;
        end else if (hazard) begin
            alu_stall = 1'b1;
        end else if (alu_valid) begin
            rf_waddr = alu_rd;
            rf_we    = (alu_rd != '0);
        end
    end

    assign memtoreg = wb_src;

    // Sticky protocol error: a load return with no load outstanding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_err <= 1'b0;
        end else if (mem_valid && q_empty) begin
            wb_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_ctrl.sv
// Testbench for wb_ctrl: directed scenarios plus randomized traffic checked
// against a queue-based reference model.
module tb_wb_ctrl;
    import wb_pkg::*;

    localparam int unsigned AW    = WB_AW;
    localparam int unsigned DEPTH = WB_DEPTH;
    localparam int unsigned PCW   = $clog2(DEPTH + 1);

    logic           clk = 1'b0;
    logic           rst;
    logic           alu_valid;
    logic [AW-1:0]  alu_rd;
    logic           alu_stall;
    logic           ld_req;
    logic [AW-1:0]  ld_rd;
    logic           ld_ready;
    logic           mem_valid;
    logic           memtoreg;
    logic           rf_we;
    logic [AW-1:0]  rf_waddr;
    logic [PCW-1:0] pending;
    logic           wb_err;

    int checks = 0;
    int errors = 0;

    // Reference model state: outstanding load destinations, oldest first.
    reg_addr_t q[$];
    bit        m_err;
    bit        exp_we;
    reg_addr_t exp_waddr;
    bit        exp_m2r;
    bit        exp_stall;

    wb_ctrl #(
        .W     (32),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_stall (alu_stall),
        .ld_req    (ld_req),
        .ld_rd     (ld_rd),
        .ld_ready  (ld_ready),
        .mem_valid (mem_valid),
        .memtoreg  (memtoreg),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .pending   (pending),
        .wb_err    (wb_err)
    );

    always #5 clk = ~clk;

    task automatic idle();
        alu_valid = 1'b0;
        alu_rd    = '0;
        ld_req    = 1'b0;
        ld_rd     = '0;
        mem_valid = 1'b0;
    endtask

    // Expected write-port outputs from the model and current inputs.
    task automatic model_comb();
        bit hit = 0;
        foreach (q[i]) if (q[i] == alu_rd) hit = 1;
        exp_we = 0; exp_waddr = '0; exp_m2r = 0; exp_stall = 0;
        if (mem_valid && q.size() != 0) begin
            exp_m2r   = 1;
            exp_waddr = q[0];
            exp_we    = (q[0] != 0);
            exp_stall = alu_valid;
        end else if (alu_valid && alu_rd != 0 && hit) begin
            exp_stall = 1;
        end else if (alu_valid) begin
            exp_waddr = alu_rd;
            exp_we    = (alu_rd != 0);
        end
    endtask

    // Apply the clock edge to the model, then advance the DUT one cycle.
    task automatic tick();
        bit do_pop  = mem_valid && q.size() != 0;
        bit do_push = ld_req && q.size() < int'(DEPTH);
        if (mem_valid && q.size() == 0) m_err = 1;
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(ld_rd);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        q.delete();
        m_err = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (pending !== PCW'(0)) begin errors++; $display("FAIL reset_pending: got %0d want 0", pending); end
        checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL reset_ld_ready: got %0b want 1", ld_ready); end
        checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL reset_wb_err: got %0b want 0", wb_err); end
        rst = 1'b0;
        #1;
        checks++; if (rf_we !== 1'b0 || memtoreg !== 1'b0 || alu_stall !== 1'b0) begin
            errors++; $display("FAIL reset_idle_outputs: got we=%0b m2r=%0b stall=%0b want 0 0 0", rf_we, memtoreg, alu_stall);
        end
        tick();
        alu_valid = 1'b1; alu_rd = AW'(7);
        #1;
        checks++; if (rf_we !== 1'b1 || rf_waddr !== AW'(7) || memtoreg !== 1'b0) begin
            errors++; $display("FAIL alu_write7: got we=%0b addr=%0d m2r=%0b want 1 7 0", rf_we, rf_waddr, memtoreg);
        end
        tick();
        idle();
    endtask

    task automatic test_fill_drain();
        int addrs[4] = '{3, 5, 9, 12};
        idle();
        for (int i = 0; i < 4; i++) begin
            ld_req = 1'b1; ld_rd = AW'(addrs[i]);
            tick();
        end
        ld_req = 1'b1; ld_rd = AW'(20);
        #1;
        checks++; if (pending !== PCW'(4) || ld_ready !== 1'b0) begin
            errors++; $display("FAIL fill_full: got pending=%0d ready=%0b want 4 0", pending, ld_ready);
        end
        tick();
        ld_req = 1'b0;
        #1;
        checks++; if (pending !== PCW'(4)) begin errors++; $display("FAIL fifth_ignored: got %0d want 4", pending); end
        for (int i = 0; i < 4; i++) begin
            mem_valid = 1'b1;
            #1;
            checks++; if (memtoreg !== 1'b1 || rf_we !== 1'b1 || rf_waddr !== AW'(addrs[i])) begin
                errors++; $display("FAIL drain_order_%0d: got m2r=%0b we=%0b addr=%0d want 1 1 %0d", i, memtoreg, rf_we, rf_waddr, addrs[i]);
            end
            tick();
        end
        mem_valid = 1'b0;
        #1;
        checks++; if (pending !== PCW'(0) || ld_ready !== 1'b1) begin
            errors++; $display("FAIL drain_empty: got pending=%0d ready=%0b want 0 1", pending, ld_ready);
        end
    endtask

    task automatic test_hazard();
        idle();
        ld_req = 1'b1; ld_rd = AW'(5);
        tick();
        ld_req = 1'b0;
        alu_valid = 1'b1; alu_rd = AW'(5);
        #1;
        checks++; if (alu_stall !== 1'b1 || rf_we !== 1'b0) begin
            errors++; $display("FAIL hazard_stall: got stall=%0b we=%0b want 1 0", alu_stall, rf_we);
        end
        tick();
        #1;
        checks++; if (alu_stall !== 1'b1 || rf_we !== 1'b0) begin
            errors++; $display("FAIL hazard_hold: got stall=%0b we=%0b want 1 0", alu_stall, rf_we);
        end
        mem_valid = 1'b1;
        #1;
        checks++; if (memtoreg !== 1'b1 || rf_we !== 1'b1 || rf_waddr !== AW'(5) || alu_stall !== 1'b1) begin
            errors++; $display("FAIL hazard_mem: got m2r=%0b we=%0b addr=%0d stall=%0b want 1 1 5 1", memtoreg, rf_we, rf_waddr, alu_stall);
        end
        tick();
        mem_valid = 1'b0;
        #1;
        checks++; if (memtoreg !== 1'b0 || rf_we !== 1'b1 || rf_waddr !== AW'(5) || alu_stall !== 1'b0) begin
            errors++; $display("FAIL hazard_release: got m2r=%0b we=%0b addr=%0d stall=%0b want 0 1 5 0", memtoreg, rf_we, rf_waddr, alu_stall);
        end
        tick();
        idle();
    endtask

    task automatic test_mem_vs_alu();
        idle();
        ld_req = 1'b1; ld_rd = AW'(4);
        tick();
        ld_req = 1'b0;
        mem_valid = 1'b1; alu_valid = 1'b1; alu_rd = AW'(8);
        #1;
        checks++; if (memtoreg !== 1'b1 || rf_waddr !== AW'(4) || alu_stall !== 1'b1) begin
            errors++; $display("FAIL mem_wins: got m2r=%0b addr=%0d stall=%0b want 1 4 1", memtoreg, rf_waddr, alu_stall);
        end
        tick();
        mem_valid = 1'b0;
        #1;
        checks++; if (memtoreg !== 1'b0 || rf_waddr !== AW'(8) || rf_we !== 1'b1 || alu_stall !== 1'b0) begin
            errors++; $display("FAIL alu_after_mem: got m2r=%0b addr=%0d we=%0b stall=%0b want 0 8 1 0", memtoreg, rf_waddr, rf_we, alu_stall);
        end
        tick();
        idle();
    endtask

    task automatic test_back_to_back();
        idle();
        for (int i = 0; i < 4; i++) begin
            ld_req = 1'b1; ld_rd = AW'(i + 1);
            tick();
        end
        ld_req = 1'b1; ld_rd = AW'(6); mem_valid = 1'b1;
        #1;
        checks++; if (rf_waddr !== AW'(1)) begin errors++; $display("FAIL full_pop_addr: got %0d want 1", rf_waddr); end
        tick();
        idle();
        #1;
        checks++; if (pending !== PCW'(3)) begin errors++; $display("FAIL full_push_pop: got %0d want 3", pending); end
        mem_valid = 1'b1;
        tick();
        // queue now holds 3, 4
        for (int i = 0; i < 10; i++) begin
            int want = (i == 0) ? 3 : (i == 1) ? 4 : 10 + i - 2;
            ld_req = 1'b1; ld_rd = AW'(10 + i); mem_valid = 1'b1;
            #1;
            checks++; if (rf_waddr !== AW'(want) || pending !== PCW'(2)) begin
                errors++; $display("FAIL wrap_%0d: got addr=%0d pending=%0d want %0d 2", i, rf_waddr, pending, want);
            end
            tick();
        end
        idle();
        #1;
        checks++; if (pending !== PCW'(2)) begin errors++; $display("FAIL wrap_count: got %0d want 2", pending); end
        mem_valid = 1'b1;
        repeat (2) tick();
        idle();
    endtask

    task automatic test_reg0_and_err();
        idle();
        ld_req = 1'b1; ld_rd = '0;
        tick();
        ld_req = 1'b0; mem_valid = 1'b1;
        #1;
        checks++; if (rf_we !== 1'b0 || memtoreg !== 1'b1) begin
            errors++; $display("FAIL load_r0: got we=%0b m2r=%0b want 0 1", rf_we, memtoreg);
        end
        tick();
        mem_valid = 1'b0;
        #1;
        checks++; if (pending !== PCW'(0) || wb_err !== 1'b0) begin
            errors++; $display("FAIL load_r0_pop: got pending=%0d err=%0b want 0 0", pending, wb_err);
        end
        mem_valid = 1'b1;
        #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL empty_return_we: got %0b want 0", rf_we); end
        tick();
        idle();
        repeat (3) tick();
        checks++; if (wb_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %0b want 1", wb_err); end
        for (int i = 0; i < 3; i++) begin
            ld_req = 1'b1; ld_rd = AW'(i + 1);
            tick();
        end
        idle();
        #2;
        rst = 1'b1;
        q.delete();
        m_err = 0;
        #1;
        checks++; if (pending !== PCW'(0) || wb_err !== 1'b0 || ld_ready !== 1'b1) begin
            errors++; $display("FAIL async_reset: got pending=%0d err=%0b ready=%0b want 0 0 1", pending, wb_err, ld_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_valid = 1'b1;
        #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL post_reset_return_we: got %0b want 0", rf_we); end
        tick();
        idle();
        #1;
        checks++; if (wb_err !== 1'b1) begin errors++; $display("FAIL post_reset_err: got %0b want 1", wb_err); end
    endtask

    task automatic test_random();
        idle();
        for (int n = 0; n < 400; n++) begin
            alu_valid = 1'($urandom_range(0, 1));
            alu_rd    = AW'($urandom_range(0, 12));
            ld_req    = ($urandom_range(0, 2) != 0);
            ld_rd     = AW'($urandom_range(0, 12));
            mem_valid = ($urandom_range(0, 2) == 0);
            #1;
            model_comb();
            checks++; if (rf_we !== exp_we || memtoreg !== exp_m2r || alu_stall !== exp_stall) begin
                errors++; $display("FAIL rand_ctl_%0d: got we=%0b m2r=%0b stall=%0b want %0b %0b %0b", n, rf_we, memtoreg, alu_stall, exp_we, exp_m2r, exp_stall);
            end
            if (exp_we) begin
                checks++; if (rf_waddr !== exp_waddr) begin
                    errors++; $display("FAIL rand_addr_%0d: got %0d want %0d", n, rf_waddr, exp_waddr);
                end
            end
            checks++; if (pending !== PCW'(q.size()) || ld_ready !== (q.size() < int'(DEPTH)) || wb_err !== m_err) begin
                errors++; $display("FAIL rand_state_%0d: got pending=%0d ready=%0b err=%0b want %0d %0b %0b", n, pending, ld_ready, wb_err, q.size(), q.size() < int'(DEPTH), m_err);
            end
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_hazard();
        test_mem_vs_alu();
        test_back_to_back();
        test_reg0_and_err();
        test_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_ctrl.md
# wb_ctrl

Writeback controller for the register-file write port. It sequences writes between single-cycle ALU results and variable-latency, in-order load returns from data memory. It drives the select of the writeback data mux (`memtoreg`), the register-file write enable and write address, and an ALU stall. It tracks outstanding load destinations in a small in-order tag queue so that an ALU write never overtakes a pending load to the same register.

## Interface
Parameters:
- `W`, 32: data width (informational; no data passes through this block)
- `AW`, 5: register address width
- `DEPTH`, 4: maximum number of outstanding loads (power of two, ≥2)

Ports:
- `clk`  in  1  the single clock; all state updates on the rising edge
- `rst`  in  1  reset, asynchronous and active-high
- `alu_valid`  in  1  ALU result ready for writeback this cycle
- `alu_rd`  in  AW  ALU destination register
- `alu_stall`  out  1  ALU writeback not accepted; upstream holds `alu_valid`/`alu_rd`
- `ld_req`  in  1  load issued; push `ld_rd` into the tag queue
- `ld_rd`  in  AW  load destination register
- `ld_ready`  out  1  tag queue can accept a load
- `mem_valid`  in  1  load data returned this cycle (oldest outstanding load)
- `memtoreg`  out  1  writeback mux select: 1 = memory data, 0 = ALU result
- `rf_we`  out  1  register-file write enable
- `rf_waddr`  out  AW  register-file write address
- `pending`  out  $clog2(DEPTH+1)  number of outstanding loads
- `wb_err`  out  1  sticky: `mem_valid` arrived with no load outstanding

## Operation
- Tag queue: circular FIFO of `DEPTH` entries of `AW` bits, with a head pointer, tail pointer and count.
  - Push when `ld_req && ld_ready`.
  - Pop when `mem_valid && count != 0`.
  - Pointers wrap modulo `DEPTH`.
  - Simultaneous push and pop leaves the count unchanged; both pointers advance.
- `ld_ready = (count != DEPTH)`. There is no push-through at full, even if a pop occurs in the same cycle. `ld_req` while `ld_ready = 0` is ignored.
- Write selection is combinational, in priority order:
  1. `mem_valid && count != 0`:
     - `memtoreg = 1`, `rf_waddr = head entry`, `rf_we = (head entry != 0)`
     - `alu_stall = alu_valid`
  2. `alu_valid` and `alu_rd != 0` and `alu_rd` equals any valid queue entry (WAW hazard):
     - `rf_we = 0`, `alu_stall = 1`, `memtoreg = 0`
  3. `alu_valid`:
     - `memtoreg = 0`, `rf_waddr = alu_rd`, `rf_we = (alu_rd != 0)`, `alu_stall = 0`
  4. Otherwise: `rf_we = 0`, `memtoreg = 0`, `rf_waddr = 0`, `alu_stall = 0`.
- The hazard compare uses only registered queue entries. A load pushed in the same cycle is not visible until the next cycle.
- `mem_valid` with count 0 does not pop and does not write. It sets `wb_err`, which is cleared only by `rst`.
- Writes to register 0 are always suppressed, but a load to register 0 still occupies a queue entry.

## Timing
- Reset values: count 0, pointers 0, `wb_err = 0`, `ld_ready = 1`, `pending = 0`. Combinational outputs with idle inputs are `rf_we = 0`, `memtoreg = 0`, `alu_stall = 0`.
- Write-selection outputs and `alu_stall` have zero latency: they are combinational from the current inputs and registered state.
- `pending`, `ld_ready` and the hazard set reflect a push or pop in the cycle after it.
- Assertion of `rst` mid-operation discards all outstanding tags immediately. Loads returned after reset then raise `wb_err`.
- ALU stall duration is unbounded. It ends in the first cycle with no `mem_valid` and no matching tag.

## Structure
- Shared package `wb_pkg` holds:
  - the default `AW`/`DEPTH` constants
  - `typedef logic [AW-1:0] reg_addr_t`
  - an enum `wb_src_e {WB_ALU = 1'b0, WB_MEM = 1'b1}` used for `memtoreg`
- One sub-module, `ld_tag_fifo`, contains:
  - the storage, pointers and count
  - full and empty flags
  - a per-entry valid vector that exposes all entries for the parallel hazard compare
- `wb_ctrl` contains the priority logic, the hazard comparators and `wb_err`.

## Test plan
- After reset with idle inputs: `ld_ready = 1`, `pending = 0`, `rf_we = 0`, `wb_err = 0`. Then `alu_valid = 1`, `alu_rd = 7` → `rf_we = 1`, `rf_waddr = 7`, `memtoreg = 0` in the same cycle.
- Push loads to 3, 5, 9, 12 → `pending = 4`, `ld_ready = 0`. A fifth `ld_req` is ignored. Four `mem_valid` pulses → `rf_waddr` = 3, 5, 9, 12 in order with `memtoreg = 1`. Then `pending = 0`.
- Load to 5 outstanding, ALU writes 5 → `alu_stall = 1`, `rf_we = 0`. `mem_valid` → write 5 from memory. Next cycle the ALU write to 5 proceeds.
- `mem_valid` and `alu_valid` (rd 8, no hazard) in the same cycle → memory write wins and `alu_stall = 1`. Next cycle `rf_waddr = 8`, `memtoreg = 0`.
- Full queue, `ld_req` and `mem_valid` together → pop only, `pending = 3`. At `pending = 2`, push and pop together → `pending` stays 2, and pointers wrap correctly across 8 or more operations.
- Load to 0 → `mem_valid` gives `rf_we = 0` and `pending` decrements. `mem_valid` with the queue empty → `wb_err = 1`, which stays set until `rst`. `rst` with 3 loads pending → `pending = 0` immediately.
